// File: rtl/lock_pkg.sv
// Shared constants for the lock access arbiter: FSM encodings, default parameters
// and the counter-width helper used by the per-user state block.
package lock_pkg;

  localparam int          N_USERS_DEF     = 4;
  localparam int          CODE_W_DEF      = 12;
  localparam int          MAX_FAIL_DEF    = 3;
  localparam int          LOCK_CYCLES_DEF = 16;
  localparam logic [11:0] RST_CODE_DEF    = 12'hA5C;

  localparam int             STATE_W  = 2;
  localparam logic [1:0]     ST_IDLE  = 2'd0;
  localparam logic [1:0]     ST_CHECK = 2'd1;
  localparam logic [1:0]     ST_RESP  = 2'd2;

  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/lock_user_state.sv
// Per-user fail counter, lockout down-counter and alarm/locked flags.
// Build option ALARM_STICKY_EN keeps alarm set past lockout expiry.
module lock_user_state
  import lock_pkg::*;
#(
  parameter int MAX_FAIL    = MAX_FAIL_DEF,
  parameter int LOCK_CYCLES = LOCK_CYCLES_DEF
) (
  input  logic clk,
  input  logic rstn,
  input  logic attempt_valid,
  input  logic match,
  input  logic cfg_hit,
  output logic alarm,
  output logic locked
);

  localparam int FAIL_W = cnt_w(MAX_FAIL);
  localparam int TMR_W  = cnt_w(LOCK_CYCLES);

  logic [FAIL_W-1:0] fail_cnt;
  logic [TMR_W-1:0]  timer;
  logic              lock_expire;
  logic              fail_trip;
  logic              alarm_clr;

  assign lock_expire = locked && (timer == TMR_W'(1));
  assign fail_trip   = attempt_valid && !match && (fail_cnt == FAIL_W'(MAX_FAIL - 1));

`ifdef ALARM_STICKY_EN
  assign alarm_clr = cfg_hit || (attempt_valid && match);
`else
  logic unused_cfg_hit;
  assign unused_cfg_hit = cfg_hit;
  assign alarm_clr      = lock_expire;
`endif

  always_ff @(posedge clk) begin
    if (rstn) begin
      fail_cnt <= '0;
      timer    <= '0;
      locked   <= 1'b0;
      alarm    <= 1'b0;
    end else begin
      if (locked) timer <= timer - 1'b1;
      if (lock_expire) locked <= 1'b0;

      // A tripping failure outranks any same-cycle clear request.
      if (fail_trip) alarm <= 1'b1;
      else if (alarm_clr) alarm <= 1'b0;

      if (attempt_valid) begin
        if (match || fail_trip) fail_cnt <= '0;
        else fail_cnt <= fail_cnt + 1'b1;
      end

      if (fail_trip) begin
        locked <= 1'b1;
        timer  <= TMR_W'(LOCK_CYCLES);
      end
    end
  end

endmodule

// File: rtl/lock_access_arbiter.sv
// Round-robin code-verification controller for the multi-user lock.
// Build option ALARM_STICKY_EN (see lock_user_state) makes alarms sticky.
//
// state    | meaning
// ST_IDLE  | waiting for an eligible (requesting, unlocked) user
// ST_CHECK | compare latched code against stored code, update user state
// ST_RESP  | ack/access visible for the granted user
module lock_access_arbiter
  import lock_pkg::*;
#(
  parameter int                N_USERS     = N_USERS_DEF,
  parameter int                CODE_W      = CODE_W_DEF,
  parameter int                MAX_FAIL    = MAX_FAIL_DEF,
  parameter int                LOCK_CYCLES = LOCK_CYCLES_DEF,
  parameter logic [CODE_W-1:0] RST_CODE    = CODE_W'(RST_CODE_DEF)
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [N_USERS-1:0]           req,
  input  logic [N_USERS*CODE_W-1:0]    code_in,
  input  logic                         cfg_we,
  input  logic [$clog2(N_USERS)-1:0]   cfg_user,
  input  logic [CODE_W-1:0]            cfg_code,
  output logic [N_USERS-1:0]           ack,
  output logic [N_USERS-1:0]           access,
  output logic [N_USERS-1:0]           alarm,
  output logic [N_USERS-1:0]           locked,
  output logic                         busy
);

  localparam int IDX_W = $clog2(N_USERS);

  logic [STATE_W-1:0] state;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   grant_idx;
  logic [IDX_W-1:0]   cand;
  logic               grant_vld;
  logic [N_USERS-1:0] eligible;
  logic [N_USERS-1:0] attempt_valid;
  logic [N_USERS-1:0] cfg_hit;
  logic [CODE_W-1:0]  code_lat;
  logic [CODE_W-1:0]  stored [N_USERS];
  logic               match;

  assign eligible = req & ~locked;
  assign busy     = (state != ST_IDLE);
  assign match    = ((code_lat ^ stored[idx]) == '0);

  // Scan from the farthest offset down so the nearest eligible user after ptr wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = ptr;
    cand      = '0;
    for (int off = N_USERS; off >= 1; off--) begin
      cand = IDX_W'((int'(ptr) + off) % N_USERS);
      if (eligible[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      state    <= ST_IDLE;
      ptr      <= IDX_W'(N_USERS - 1);
      idx      <= '0;
      code_lat <= '0;
      ack      <= '0;
      access   <= '0;
      for (int i = 0; i < N_USERS; i++) stored[i] <= RST_CODE;
    end else begin
      ack    <= '0;
      access <= '0;
      if (cfg_we && (int'(cfg_user) < N_USERS)) stored[cfg_user] <= cfg_code;
      case (state)
        ST_IDLE: begin
          if (grant_vld) begin
            idx      <= grant_idx;
            ptr      <= grant_idx;
            code_lat <= code_in[grant_idx*CODE_W +: CODE_W];
            state    <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          ack[idx]    <= 1'b1;
          access[idx] <= match;
          state       <= ST_RESP;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < N_USERS; i++) begin : g_user
    assign attempt_valid[i] = (state == ST_CHECK) && (idx == IDX_W'(i));
    assign cfg_hit[i]       = cfg_we && (cfg_user == IDX_W'(i));

    lock_user_state #(
      .MAX_FAIL    (MAX_FAIL),
      .LOCK_CYCLES (LOCK_CYCLES)
    ) u_state (
      .clk           (clk),
      .rstn          (rstn),
      .attempt_valid (attempt_valid[i]),
      .match         (match),
      .cfg_hit       (cfg_hit[i]),
      .alarm         (alarm[i]),
      .locked        (locked[i])
    );
  end

endmodule

// File: tb/tb_lock_access_arbiter.sv
// Scoreboard bench for lock_access_arbiter: stimulus pushes expected responses,
// a negedge monitor pops and compares whenever an ack appears.
module tb_lock_access_arbiter;

  localparam int N  = 4;
  localparam int CW = 12;

  logic            clk = 1'b0;
  logic            rstn;
  logic [N-1:0]    req;
  logic [N*CW-1:0] code_in;
  logic            cfg_we;
  logic [1:0]      cfg_user;
  logic [CW-1:0]   cfg_code;
  logic [N-1:0]    ack, access, alarm, locked;
  logic            busy;

  always #5 clk = ~clk;

  lock_access_arbiter dut (
    .clk      (clk),
    .rstn     (rstn),
    .req      (req),
    .code_in  (code_in),
    .cfg_we   (cfg_we),
    .cfg_user (cfg_user),
    .cfg_code (cfg_code),
    .ack      (ack),
    .access   (access),
    .alarm    (alarm),
    .locked   (locked),
    .busy     (busy)
  );

  typedef struct packed {
    logic [3:0] ack;
    logic [3:0] access;
    logic [3:0] alarm;
    logic [3:0] locked;
  } exp_t;

  exp_t sb[$];
  exp_t mon_got, mon_exp;
  int   errors = 0;
  int   checks = 0;

  function automatic exp_t mk(input logic [3:0] a, input logic [3:0] b,
                              input logic [3:0] c, input logic [3:0] d);
    return {a, b, c, d};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ack !== '0) begin
      mon_got = {ack, access, alarm, locked};
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got %h expected no ack", mon_got);
      end else begin
        mon_exp = sb.pop_front();
        check("ack_resp{ack,access,alarm,locked}", 32'(mon_got), 32'(mon_exp));
      end
    end
  end

  task automatic wait_ack(output logic [3:0] a, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ack == '0 && n < 80);
    a = ack;
    if (a == '0) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: got no ack expected one within 80 cycles");
    end
  endtask

  task automatic attempt(input int u, input logic [CW-1:0] c, input exp_t e, output int n);
    logic [3:0] a;
    sb.push_back(e);
    code_in[u*CW +: CW] = c;
    req[u] = 1'b1;
    wait_ack(a, n);
    req[u] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] a;
    int n, cnt;
    req = '0; code_in = '0; cfg_we = 1'b0; cfg_user = '0; cfg_code = '0;
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({ack, access, alarm, locked, busy}), 32'd0);
    rstn = 1'b0;

    // correct code, latency and return to idle
    attempt(0, 12'hA5C, mk(4'b0001, 4'b0001, 4'b0000, 4'b0000), n);
    check("latency", 32'(n), 32'd2);
    @(negedge clk);
    check("busy_after_resp", 32'(busy), 32'd0);

    // three failures lock user1 for 16 cycles
    attempt(1, 12'h000, mk(4'b0010, 4'b0000, 4'b0000, 4'b0000), n);
    attempt(1, 12'h000, mk(4'b0010, 4'b0000, 4'b0000, 4'b0000), n);
    attempt(1, 12'h000, mk(4'b0010, 4'b0000, 4'b0010, 4'b0010), n);
    cnt = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (locked[1]) cnt++;
      else break;
    end
    check("lock_duration", 32'(cnt), 32'd16);
    check("alarm_locked_cleared", 32'({alarm, locked}), 32'd0);

    // all four requesting from reset: round robin 0,1,2,3
    rstn = 1'b1;
    req = 4'b1111;
    code_in = {4{12'hA5C}};
    for (int k = 0; k < 4; k++) sb.push_back(mk(4'(1 << k), 4'(1 << k), 4'b0000, 4'b0000));
    repeat (2) @(negedge clk);
    rstn = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_ack(a, n);
      if (k > 0) check("rr_spacing", 32'(n), 32'd3);
      check("rr_busy", 32'(busy), 32'd1);
      req = req & ~a;
    end
    req = '0;

    // config write to user2
    @(negedge clk);
    cfg_we = 1'b1; cfg_user = 2'd2; cfg_code = 12'h123;
    @(negedge clk);
    cfg_we = 1'b0;
    attempt(2, 12'h123, mk(4'b0100, 4'b0100, 4'b0000, 4'b0000), n);
    attempt(2, 12'hA5C, mk(4'b0100, 4'b0000, 4'b0000, 4'b0000), n);
    attempt(2, 12'h000, mk(4'b0100, 4'b0000, 4'b0000, 4'b0000), n);
    attempt(2, 12'h000, mk(4'b0100, 4'b0000, 4'b0100, 4'b0100), n);
    for (int i = 0; i < 40 && locked != '0; i++) @(negedge clk);
    check("user2_unlock", 32'(locked), 32'd0);

    // locked user1 is masked while user3 is served
    attempt(1, 12'h000, mk(4'b0010, 4'b0000, 4'b0000, 4'b0000), n);
    attempt(1, 12'h000, mk(4'b0010, 4'b0000, 4'b0000, 4'b0000), n);
    attempt(1, 12'h000, mk(4'b0010, 4'b0000, 4'b0010, 4'b0010), n);
    sb.push_back(mk(4'b1000, 4'b1000, 4'b0010, 4'b0010));
    sb.push_back(mk(4'b0010, 4'b0010, 4'b0000, 4'b0000));
    code_in[1*CW +: CW] = 12'hA5C;
    code_in[3*CW +: CW] = 12'hA5C;
    req = 4'b1010;
    wait_ack(a, n);
    req = req & ~a;
    check("lockout_serves_other", 32'(a), 32'h8);
    wait_ack(a, n);
    req = req & ~a;
    check("served_after_unlock", 32'(a), 32'h2);
    req = '0;

    // reset while in CHECK
    @(negedge clk);
    cfg_we = 1'b1; cfg_user = 2'd0; cfg_code = 12'h111;
    @(negedge clk);
    cfg_we = 1'b0;
    code_in[0 +: CW] = 12'h111;
    req[0] = 1'b1;
    @(negedge clk);
    check("busy_in_check", 32'(busy), 32'd1);
    rstn = 1'b1;
    @(negedge clk);
    check("reset_in_check", 32'({ack, access, alarm, locked, busy}), 32'd0);
    rstn = 1'b0;
    req = '0;
    repeat (4) @(negedge clk);
    attempt(0, 12'hA5C, mk(4'b0001, 4'b0001, 4'b0000, 4'b0000), n);
    attempt(0, 12'h111, mk(4'b0001, 4'b0000, 4'b0000, 4'b0000), n);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
